// File: rtl/uart_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl_if
// Description : Frame input, register write/read and TX byte handshakes
//               between the UART command controller and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_ctrl_if;
    logic [8:0]  frame;
    logic        frame_valid;
    logic        wr_valid;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        rd_req;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  err_count;

    // Environment side: UART receiver, config block and UART transmitter
    modport master (
        output frame, frame_valid, wr_ready, rd_valid, rd_data, tx_ready,
        input  wr_valid, wr_addr, wr_data, rd_req, tx_data, tx_valid, busy, err_count
    );

    // Controller side
    modport slave (
        input  frame, frame_valid, wr_ready, rd_valid, rd_data, tx_ready,
        output wr_valid, wr_addr, wr_data, rd_req, tx_data, tx_valid, busy, err_count
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Decodes UART command frames into register writes and reads of
//               the VGA config block and returns read data as two TX bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
    parameter int TIMEOUT = 50000
) (
    input  logic           clk,
    input  logic           rst,
    uart_cmd_ctrl_if.slave bus
);

    localparam int              c_TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_TMO_LAST   = c_TW'(TIMEOUT - 1);
    localparam logic [3:0]      c_OP_WRITE   = 4'h1;
    localparam logic [3:0]      c_OP_READ    = 4'h2;
    localparam logic [7:0]      c_ERR_MAX    = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DATA_HI = 3'd1,
        S_DATA_LO = 3'd2,
        S_WRITE   = 3'd3,
        S_RD_REQ  = 3'd4,
        S_RD_WAIT = 3'd5,
        S_TX_HI   = 3'd6,
        S_TX_LO   = 3'd7
    } state_t;

    // Header decode shared by IDLE and the mid-command resync path;
    // anything that is not a legal header maps to IDLE.
    function automatic state_t f_decode(input logic [8:0] f);
        if (f[8] && (f[7:4] == c_OP_WRITE)) return S_DATA_HI;
        if (f[8] && (f[7:4] == c_OP_READ))  return S_RD_REQ;
        return S_IDLE;
    endfunction

    state_t          r_state;
    state_t          w_state_nx;
    logic [c_TW-1:0] r_tmo;
    logic [3:0]      r_addr;
    logic [15:0]     r_wr_data;
    logic [7:0]      r_rd_lo;
    logic [7:0]      r_tx_data;
    logic            r_wr_valid;
    logic            r_rd_req;
    logic            r_tx_valid;
    logic            r_busy;
    logic [7:0]      r_err;

    logic            w_err;
    logic            w_accept;
    logic            w_ld_addr;
    logic            w_ld_hi;
    logic            w_ld_lo;
    logic            w_ld_rd;
    logic            w_tx_adv;
    logic            w_tmo_run;

    always_comb begin
        w_state_nx = r_state;
        w_err      = 1'b0;
        w_accept   = 1'b0;
        w_ld_addr  = 1'b0;
        w_ld_hi    = 1'b0;
        w_ld_lo    = 1'b0;
        w_ld_rd    = 1'b0;
        w_tx_adv   = 1'b0;
        w_tmo_run  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.frame_valid) begin
                    w_accept   = 1'b1;
                    w_state_nx = f_decode(bus.frame);
                    w_err      = (w_state_nx == S_IDLE);
                    w_ld_addr  = (w_state_nx != S_IDLE);
                end
            end
            S_DATA_HI, S_DATA_LO: begin
                if (bus.frame_valid) begin
                    w_accept = 1'b1;
                    if (!bus.frame[8]) begin
                        w_ld_hi    = (r_state == S_DATA_HI);
                        w_ld_lo    = (r_state == S_DATA_LO);
                        w_state_nx = (r_state == S_DATA_HI) ? S_DATA_LO : S_WRITE;
                    end else begin
                        // A header mid-command drops the command and restarts on it
                        w_err      = 1'b1;
                        w_state_nx = f_decode(bus.frame);
                        w_ld_addr  = (w_state_nx != S_IDLE);
                    end
                end else begin
                    w_tmo_run = 1'b1;
                end
            end
            S_WRITE: begin
                w_err = bus.frame_valid;
                if (bus.wr_ready) w_state_nx = S_IDLE;
            end
            S_RD_REQ: begin
                w_err      = bus.frame_valid;
                w_state_nx = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_err = bus.frame_valid;
                if (bus.rd_valid) begin
                    w_ld_rd    = 1'b1;
                    w_state_nx = S_TX_HI;
                end else begin
                    w_tmo_run = 1'b1;
                end
            end
            S_TX_HI: begin
                w_err = bus.frame_valid;
                if (bus.tx_ready) begin
                    w_tx_adv   = 1'b1;
                    w_state_nx = S_TX_LO;
                end
            end
            S_TX_LO: begin
                w_err = bus.frame_valid;
                if (bus.tx_ready) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase

        if (w_tmo_run && (r_tmo == c_TMO_LAST)) begin
            w_state_nx = S_IDLE;
            w_err      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_tmo      <= '0;
            r_addr     <= '0;
            r_wr_data  <= '0;
            r_rd_lo    <= '0;
            r_tx_data  <= '0;
            r_wr_valid <= 1'b0;
            r_rd_req   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= '0;
        end else begin
            r_state <= w_state_nx;

            if ((w_state_nx != r_state) || w_accept) r_tmo <= '0;
            else if (w_tmo_run)                      r_tmo <= r_tmo + 1'b1;

            if (w_ld_addr) r_addr          <= bus.frame[3:0];
            if (w_ld_hi)   r_wr_data[15:8] <= bus.frame[7:0];
            if (w_ld_lo)   r_wr_data[7:0]  <= bus.frame[7:0];

            if (w_ld_rd) begin
                r_tx_data <= bus.rd_data[15:8];
                r_rd_lo   <= bus.rd_data[7:0];
            end else if (w_tx_adv) begin
                r_tx_data <= r_rd_lo;
            end

            // Handshake outputs are registered images of the next state
            r_wr_valid <= (w_state_nx == S_WRITE);
            r_rd_req   <= (w_state_nx == S_RD_REQ);
            r_tx_valid <= (w_state_nx == S_TX_HI) || (w_state_nx == S_TX_LO);
            r_busy     <= (w_state_nx != S_IDLE);

            if (w_err && (r_err != c_ERR_MAX)) r_err <= r_err + 8'd1;
        end
    end

    assign bus.wr_valid  = r_wr_valid;
    assign bus.wr_addr   = r_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.rd_req    = r_rd_req;
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.busy      = r_busy;
    assign bus.err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Self-checking bench for uart_cmd_ctrl with directed scenarios
//               and a randomized command stream against a command-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.frame       = '0;
        bus.frame_valid = 1'b0;
        bus.wr_ready    = 1'b0;
        bus.rd_valid    = 1'b0;
        bus.rd_data     = '0;
        bus.tx_ready    = 1'b0;
    endtask

    // Presents one frame for exactly one rising edge; returns on the next falling edge.
    task automatic send_frame(input logic [8:0] f);
        bus.frame       = f;
        bus.frame_valid = 1'b1;
        @(negedge clk);
        bus.frame_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [8:0] rand_bad();
        logic [3:0] op;
        if ($urandom_range(0, 1) == 1) return {1'b0, 8'($urandom)};
        op = 4'($urandom);
        if (op == 4'h1 || op == 4'h2) op = 4'h0;
        return {1'b1, op, 4'($urandom)};
    endfunction

    task automatic test_reset();
        logic [39:0] outs;
        rst = 1'b0;
        idle_inputs();
        bus.frame       = 9'h113;
        bus.frame_valid = 1'b1;
        repeat (3) @(negedge clk);
        outs = {bus.wr_valid, bus.wr_addr, bus.wr_data, bus.rd_req, bus.tx_valid,
                bus.tx_data, bus.busy, bus.err_count};
        checks++;
        if (outs !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", outs);
        end
        bus.frame_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.err_count} !== 9'd0) begin
            errors++;
            $display("FAIL reset_frame_ignored got busy=%b err=%0d want 0/0", bus.busy, bus.err_count);
        end
    endtask

    task automatic test_write();
        do_reset();
        bus.wr_ready = 1'b1;
        send_frame(9'h113);
        send_frame(9'h0AB);
        send_frame(9'h0CD);
        checks++;
        if ({bus.wr_valid, bus.wr_addr, bus.wr_data} !== {1'b1, 4'h3, 16'hABCD}) begin
            errors++;
            $display("FAIL write_req got v=%b a=%h d=%h want 1/3/abcd", bus.wr_valid, bus.wr_addr, bus.wr_data);
        end
        @(negedge clk);
        checks++;
        if ({bus.wr_valid, bus.busy, bus.err_count} !== 10'd0) begin
            errors++;
            $display("FAIL write_done got v=%b busy=%b err=%0d want 0/0/0", bus.wr_valid, bus.busy, bus.err_count);
        end
        bus.wr_ready = 1'b0;
    endtask

    task automatic test_read();
        logic [7:0] exp_b [2];
        exp_b[0] = 8'h12;
        exp_b[1] = 8'h34;
        do_reset();
        send_frame(9'h125);
        checks++;
        if ({bus.rd_req, bus.wr_addr} !== {1'b1, 4'h5}) begin
            errors++;
            $display("FAIL read_req got r=%b a=%h want 1/5", bus.rd_req, bus.wr_addr);
        end
        @(negedge clk);
        checks++;
        if ({bus.rd_req, bus.busy} !== 2'b01) begin
            errors++;
            $display("FAIL read_req_pulse got r=%b busy=%b want 0/1", bus.rd_req, bus.busy);
        end
        repeat (3) @(negedge clk);
        bus.rd_valid = 1'b1;
        bus.rd_data  = 16'h1234;
        @(negedge clk);
        bus.rd_valid = 1'b0;
        bus.rd_data  = 16'hDEAD;
        for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < 4; s++) begin
                checks++;
                if ({bus.tx_valid, bus.tx_data} !== {1'b1, exp_b[b]}) begin
                    errors++;
                    $display("FAIL read_tx byte%0d got v=%b d=%h want 1/%h", b, bus.tx_valid, bus.tx_data, exp_b[b]);
                end
                bus.tx_ready = (s == 3);
                @(negedge clk);
            end
            bus.tx_ready = 1'b0;
        end
        checks++;
        if ({bus.tx_valid, bus.busy, bus.err_count} !== 10'd0) begin
            errors++;
            $display("FAIL read_done got v=%b busy=%b err=%0d want 0/0/0", bus.tx_valid, bus.busy, bus.err_count);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        send_frame(9'h0AA);
        checks++;
        if ({bus.wr_valid, bus.rd_req, bus.tx_valid, bus.busy} !== 4'd0) begin
            errors++;
            $display("FAIL illegal_data_outs got %b want 0000", {bus.wr_valid, bus.rd_req, bus.tx_valid, bus.busy});
        end
        send_frame(9'h1F0);
        checks++;
        if ({bus.wr_valid, bus.rd_req, bus.tx_valid, bus.busy} !== 4'd0) begin
            errors++;
            $display("FAIL illegal_hdr_outs got %b want 0000", {bus.wr_valid, bus.rd_req, bus.tx_valid, bus.busy});
        end
        checks++;
        if (bus.err_count !== 8'd2) begin
            errors++;
            $display("FAIL illegal_err got %0d want 2", bus.err_count);
        end
    endtask

    task automatic test_resync();
        do_reset();
        bus.wr_ready = 1'b1;
        send_frame(9'h111);
        send_frame(9'h055);
        send_frame(9'h124);
        checks++;
        if ({bus.rd_req, bus.wr_addr, bus.wr_valid, bus.err_count} !== {1'b1, 4'h4, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL resync got r=%b a=%h wv=%b err=%0d want 1/4/0/1",
                     bus.rd_req, bus.wr_addr, bus.wr_valid, bus.err_count);
        end
        bus.wr_ready = 1'b0;
        @(negedge clk);
        bus.rd_valid = 1'b1;
        @(negedge clk);
        bus.rd_valid = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.tx_ready = 1'b0;
        checks++;
        if ({bus.busy, bus.wr_valid, bus.err_count} !== {2'b00, 8'd1}) begin
            errors++;
            $display("FAIL resync_done got busy=%b wv=%b err=%0d want 0/0/1", bus.busy, bus.wr_valid, bus.err_count);
        end
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        send_frame(9'h111);
        cnt = 0;
        while (bus.busy && cnt < 40) begin cnt++; @(negedge clk); end
        checks++;
        if (cnt != TIMEOUT || bus.err_count !== 8'd1) begin
            errors++;
            $display("FAIL timeout_data busy_cycles=%0d err=%0d want %0d/1", cnt, bus.err_count, TIMEOUT);
        end
        send_frame(9'h122);
        cnt = 0;
        while (bus.busy && cnt < 40) begin cnt++; @(negedge clk); end
        checks++;
        if (cnt != TIMEOUT + 1 || bus.err_count !== 8'd2) begin
            errors++;
            $display("FAIL timeout_rdwait busy_cycles=%0d err=%0d want %0d/2", cnt, bus.err_count, TIMEOUT + 1);
        end
        // A frame on the final allowed cycle is still accepted
        send_frame(9'h117);
        repeat (TIMEOUT - 1) @(negedge clk);
        send_frame(9'h0BB);
        repeat (TIMEOUT - 1) @(negedge clk);
        send_frame(9'h0CC);
        checks++;
        if ({bus.wr_valid, bus.wr_addr, bus.wr_data, bus.err_count} !== {1'b1, 4'h7, 16'hBBCC, 8'd2}) begin
            errors++;
            $display("FAIL timeout_edge got v=%b a=%h d=%h err=%0d want 1/7/bbcc/2",
                     bus.wr_valid, bus.wr_addr, bus.wr_data, bus.err_count);
        end
        bus.wr_ready = 1'b1;
        @(negedge clk);
        bus.wr_ready = 1'b0;
    endtask

    task automatic test_saturate();
        int exp;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send_frame(rand_bad());
            exp = (i + 1 > 255) ? 255 : i + 1;
            if (i == 9 || i == 253 || i == 254 || i == 299) begin
                checks++;
                if (bus.err_count !== 8'(exp)) begin
                    errors++;
                    $display("FAIL saturate after %0d errors got %0d want %0d", i + 1, bus.err_count, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [39:0] outs;
        do_reset();
        send_frame(9'h127);
        @(negedge clk);
        bus.rd_valid = 1'b1;
        bus.rd_data  = 16'hBEEF;
        @(negedge clk);
        bus.rd_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'hBE}) begin
            errors++;
            $display("FAIL rstmid_stall got v=%b d=%h want 1/be", bus.tx_valid, bus.tx_data);
        end
        rst             = 1'b0;
        bus.frame       = 9'h113;
        bus.frame_valid = 1'b1;
        @(negedge clk);
        outs = {bus.wr_valid, bus.wr_addr, bus.wr_data, bus.rd_req, bus.tx_valid,
                bus.tx_data, bus.busy, bus.err_count};
        checks++;
        if (outs !== 40'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got %h want 0", outs);
        end
        bus.frame_valid = 1'b0;
        rst = 1'b1;
        bus.tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.tx_ready = 1'b0;
        checks++;
        if ({bus.tx_valid, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_quiet got v=%b busy=%b want 0/0", bus.tx_valid, bus.busy);
        end
        bus.wr_ready = 1'b1;
        send_frame(9'h11A);
        send_frame(9'h012);
        send_frame(9'h034);
        checks++;
        if ({bus.wr_valid, bus.wr_addr, bus.wr_data, bus.err_count} !== {1'b1, 4'hA, 16'h1234, 8'd0}) begin
            errors++;
            $display("FAIL rstmid_next got v=%b a=%h d=%h err=%0d want 1/a/1234/0",
                     bus.wr_valid, bus.wr_addr, bus.wr_data, bus.err_count);
        end
        @(negedge clk);
        bus.wr_ready = 1'b0;
    endtask

    // Random command stream; the model tracks only command-level results.
    task automatic test_back_to_back();
        int          exp_err;
        int          kind;
        int          k;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [7:0]  exp_b [2];
        logic        stray;
        do_reset();
        exp_err = 0;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            addr = 4'($urandom);
            data = 16'($urandom);
            if (kind == 0) begin
                send_frame({1'b1, 4'h1, addr});
                repeat ($urandom_range(0, 5)) @(negedge clk);
                send_frame({1'b0, data[15:8]});
                repeat ($urandom_range(0, 5)) @(negedge clk);
                send_frame({1'b0, data[7:0]});
                k     = $urandom_range(0, 3);
                stray = (k > 0) && ($urandom_range(0, 1) == 1);
                if (stray) exp_err++;
                for (int s = 0; s <= k; s++) begin
                    checks++;
                    if ({bus.wr_valid, bus.wr_addr, bus.wr_data} !== {1'b1, addr, data}) begin
                        errors++;
                        $display("FAIL rnd_write[%0d] got v=%b a=%h d=%h want 1/%h/%h",
                                 n, bus.wr_valid, bus.wr_addr, bus.wr_data, addr, data);
                    end
                    bus.wr_ready = (s == k);
                    if (s == 0 && stray) send_frame(rand_bad());
                    else @(negedge clk);
                end
                bus.wr_ready = 1'b0;
                checks++;
                if (bus.wr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_write_end[%0d] got v=%b want 0", n, bus.wr_valid);
                end
            end else if (kind == 1) begin
                exp_b[0] = data[15:8];
                exp_b[1] = data[7:0];
                send_frame({1'b1, 4'h2, addr});
                checks++;
                if ({bus.rd_req, bus.wr_addr} !== {1'b1, addr}) begin
                    errors++;
                    $display("FAIL rnd_rdreq[%0d] got r=%b a=%h want 1/%h", n, bus.rd_req, bus.wr_addr, addr);
                end
                @(negedge clk);
                repeat ($urandom_range(0, 5)) @(negedge clk);
                bus.rd_valid = 1'b1;
                bus.rd_data  = data;
                @(negedge clk);
                bus.rd_valid = 1'b0;
                bus.rd_data  = 16'($urandom);
                for (int b = 0; b < 2; b++) begin
                    k = $urandom_range(0, 3);
                    for (int s = 0; s <= k; s++) begin
                        checks++;
                        if ({bus.tx_valid, bus.tx_data} !== {1'b1, exp_b[b]}) begin
                            errors++;
                            $display("FAIL rnd_tx[%0d] byte%0d got v=%b d=%h want 1/%h",
                                     n, b, bus.tx_valid, bus.tx_data, exp_b[b]);
                        end
                        bus.tx_ready = (s == k);
                        @(negedge clk);
                    end
                    bus.tx_ready = 1'b0;
                end
                checks++;
                if ({bus.tx_valid, bus.busy} !== 2'b00) begin
                    errors++;
                    $display("FAIL rnd_read_end[%0d] got v=%b busy=%b want 0/0", n, bus.tx_valid, bus.busy);
                end
            end else begin
                send_frame(rand_bad());
                exp_err++;
            end
            checks++;
            if (bus.err_count !== 8'(exp_err)) begin
                errors++;
                $display("FAIL rnd_err[%0d] got %0d want %0d", n, bus.err_count, exp_err);
            end
        end
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_illegal();
        test_resync();
        test_timeout();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
